// File: rtl/envelope_bank.sv
// Bank of ADSR envelope generators with a shared time-multiplexed update path.
// A tick every TICK_DIV clocks starts a sweep that services one voice per clock.
// Note events act immediately; a service that coincides with an event is dropped.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | silent, accumulator held at zero
// ST_ATTACK  | rising by attack_rate per tick toward full scale
// ST_DECAY   | falling by decay_rate per tick toward the sustain floor
// ST_SUSTAIN | tracking sustain_level every tick
// ST_RELEASE | falling by release_rate per tick toward zero
module envelope_bank #(
  parameter int VOICES     = 8,
  parameter int OUT_WIDTH  = 16,
  parameter int FRAC_WIDTH = 8,
  parameter int TICK_DIV   = 1042,
  parameter int LEGATO     = 1,
  localparam int ACC_WIDTH = OUT_WIDTH + FRAC_WIDTH
) (
  input  logic                          clock_50_000_000,
  input  logic                          reset_l,
  input  logic [VOICES-1:0]             note_on,
  input  logic [VOICES-1:0]             note_off,
  input  logic [ACC_WIDTH-1:0]          attack_rate,
  input  logic [ACC_WIDTH-1:0]          decay_rate,
  input  logic [ACC_WIDTH-1:0]          release_rate,
  input  logic [OUT_WIDTH-1:0]          sustain_level,
  output logic [VOICES*OUT_WIDTH-1:0]   envelope,
  output logic [VOICES-1:0]             envelope_end,
  output logic [VOICES-1:0]             active
);

  localparam int IDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(VOICES - 1);
  localparam logic [ACC_WIDTH-1:0] ACC_ONES = '1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_ATTACK, ST_DECAY, ST_SUSTAIN, ST_RELEASE
  } state_t;

  state_t               state_q  [VOICES];
  state_t               state_d  [VOICES];
  logic [ACC_WIDTH-1:0] acc_q    [VOICES];
  logic [ACC_WIDTH-1:0] acc_d    [VOICES];
  logic [OUT_WIDTH-1:0] env_q    [VOICES];
  logic [ACC_WIDTH:0]   att_sum  [VOICES];
  logic [ACC_WIDTH:0]   dec_diff [VOICES];
  logic [ACC_WIDTH:0]   rel_diff [VOICES];
  logic [VOICES-1:0]    svc_hit;
  logic [VOICES-1:0]    end_d;

  logic [CNT_W-1:0]     tick_cnt;
  logic                 sweep_on;
  logic [IDX_W-1:0]     svc_idx;
  logic [ACC_WIDTH-1:0] sus_floor;

  assign sus_floor = ACC_WIDTH'(sustain_level) << FRAC_WIDTH;

  // One guard bit on every update so overflow and underflow are visible.
  for (genvar g = 0; g < VOICES; g++) begin : g_voice
    assign att_sum[g]  = {1'b0, acc_q[g]} + {1'b0, attack_rate};
    assign dec_diff[g] = {1'b0, acc_q[g]} - {1'b0, decay_rate};
    assign rel_diff[g] = {1'b0, acc_q[g]} - {1'b0, release_rate};
    assign envelope[g*OUT_WIDTH +: OUT_WIDTH] = env_q[g];
    assign active[g] = (state_q[g] != ST_IDLE);
  end

  // Tick divider and sweep pointer: the tick edge arms the sweep, voice v is served v+1 clocks later.
  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) begin
      tick_cnt <= '0;
      sweep_on <= 1'b0;
      svc_idx  <= '0;
    end else begin
      if (tick_cnt == CNT_LAST) tick_cnt <= '0;
      else                      tick_cnt <= tick_cnt + CNT_W'(1);
      if (tick_cnt == CNT_LAST) begin
        sweep_on <= 1'b1;
        svc_idx  <= '0;
      end else if (sweep_on) begin
        if (svc_idx == IDX_LAST) sweep_on <= 1'b0;
        else                     svc_idx  <= svc_idx + IDX_W'(1);
      end
    end
  end

  // Per-voice next state: events first, otherwise the scheduled service.
  always_comb begin
    for (int v = 0; v < VOICES; v++) begin
      state_d[v] = state_q[v];
      acc_d[v]   = acc_q[v];
      svc_hit[v] = 1'b0;
      end_d[v]   = 1'b0;
      if (note_on[v]) begin
        state_d[v] = ST_ATTACK;
        if (LEGATO == 0) acc_d[v] = '0;
      end else if (note_off[v] && (state_q[v] == ST_ATTACK || state_q[v] == ST_DECAY ||
                                   state_q[v] == ST_SUSTAIN)) begin
        state_d[v] = ST_RELEASE;
      end else if (sweep_on && (svc_idx == IDX_W'(v))) begin
        svc_hit[v] = 1'b1;
        case (state_q[v])
          ST_ATTACK: begin
            if ((attack_rate == '0) || (att_sum[v] >= {1'b0, ACC_ONES})) begin
              acc_d[v]   = ACC_ONES;
              state_d[v] = ST_DECAY;
            end else begin
              acc_d[v] = att_sum[v][ACC_WIDTH-1:0];
            end
          end
          ST_DECAY: begin
            if ((decay_rate == '0) || dec_diff[v][ACC_WIDTH] ||
                (dec_diff[v][ACC_WIDTH-1:0] <= sus_floor)) begin
              acc_d[v]   = sus_floor;
              state_d[v] = ST_SUSTAIN;
            end else begin
              acc_d[v] = dec_diff[v][ACC_WIDTH-1:0];
            end
          end
          ST_SUSTAIN: acc_d[v] = sus_floor;
          ST_RELEASE: begin
            if ((release_rate == '0) || rel_diff[v][ACC_WIDTH] ||
                (rel_diff[v][ACC_WIDTH-1:0] == '0)) begin
              acc_d[v]   = '0;
              state_d[v] = ST_IDLE;
              end_d[v]   = 1'b1;
            end else begin
              acc_d[v] = rel_diff[v][ACC_WIDTH-1:0];
            end
          end
          default: acc_d[v] = '0;
        endcase
      end
    end
  end

  // Voice registers; the envelope slice only moves on a service edge.
  always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
    if (!reset_l) begin
      for (int v = 0; v < VOICES; v++) begin
        state_q[v] <= ST_IDLE;
        acc_q[v]   <= '0;
        env_q[v]   <= '0;
      end
      envelope_end <= '0;
    end else begin
      for (int v = 0; v < VOICES; v++) begin
        state_q[v] <= state_d[v];
        acc_q[v]   <= acc_d[v];
        if (svc_hit[v]) env_q[v] <= acc_d[v][ACC_WIDTH-1:FRAC_WIDTH];
      end
      envelope_end <= end_d;
    end
  end

endmodule

// File: tb/tb_envelope_bank.sv
// Directed bench for envelope_bank: expected envelope values per voice are queued
// by the stimulus and popped by a monitor at each voice's service slot.
module tb_envelope_bank;
  localparam int V  = 4;
  localparam int OW = 16;
  localparam int FW = 8;
  localparam int AW = OW + FW;
  localparam int TD = 8;

  logic            clock_50_000_000 = 1'b0;
  logic            reset_l = 1'b0;
  logic [V-1:0]    note_on = '0, note_off = '0, note_on0 = '0, note_off0 = '0;
  logic [AW-1:0]   attack_rate = '0, decay_rate = '0, release_rate = '0;
  logic [OW-1:0]   sustain_level = '0;
  logic [V*OW-1:0] envelope, envelope0;
  logic [V-1:0]    envelope_end, envelope_end0, active, active0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int exp_end [V];
  logic [OW-1:0] q [V][$];
  logic [OW-1:0] q0 [$];

  envelope_bank #(.VOICES(V), .OUT_WIDTH(OW), .FRAC_WIDTH(FW), .TICK_DIV(TD), .LEGATO(1)) dut (
    .clock_50_000_000(clock_50_000_000), .reset_l(reset_l),
    .note_on(note_on), .note_off(note_off),
    .attack_rate(attack_rate), .decay_rate(decay_rate), .release_rate(release_rate),
    .sustain_level(sustain_level),
    .envelope(envelope), .envelope_end(envelope_end), .active(active));

  envelope_bank #(.VOICES(V), .OUT_WIDTH(OW), .FRAC_WIDTH(FW), .TICK_DIV(TD), .LEGATO(0)) dut0 (
    .clock_50_000_000(clock_50_000_000), .reset_l(reset_l),
    .note_on(note_on0), .note_off(note_off0),
    .attack_rate(attack_rate), .decay_rate(decay_rate), .release_rate(release_rate),
    .sustain_level(sustain_level),
    .envelope(envelope0), .envelope_end(envelope_end0), .active(active0));

  always #5 clock_50_000_000 = ~clock_50_000_000;

  always @(posedge clock_50_000_000 or negedge reset_l)
    if (!reset_l) cyc <= 0;
    else          cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cyc=%0d: got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // Service slot of voice v: edge TD*k+1+v after reset release, k >= 1.
  always @(posedge clock_50_000_000) begin
    #1;
    if (reset_l) begin
      for (int v = 0; v < V; v++) begin
        if (cyc > TD && ((cyc - 1 - v) % TD) == 0) begin
          if (q[v].size() > 0)
            chk($sformatf("env_v%0d", v), 32'(envelope[v*OW +: OW]), 32'(q[v].pop_front()));
          if (v == 1 && q0.size() > 0)
            chk("env_nolegato_v1", 32'(envelope0[OW +: OW]), 32'(q0.pop_front()));
        end
        chk($sformatf("end_v%0d", v), 32'(envelope_end[v]), 32'(cyc == exp_end[v]));
      end
    end
  end

  task automatic wait_cyc(input int n);
    int guard;
    guard = 0;
    while (cyc != n) begin
      @(negedge clock_50_000_000);
      guard++;
      if (guard > 3000 || cyc > n) begin
        $display("FAIL wait_cyc: reached=%0d want=%0d", cyc, n);
        $fatal(1, "schedule lost");
      end
    end
  endtask

  task automatic pulse(input logic [V-1:0] on, input logic [V-1:0] off,
                       input logic [V-1:0] on0, input logic [V-1:0] off0);
    note_on = on; note_off = off; note_on0 = on0; note_off0 = off0;
    @(negedge clock_50_000_000);
    note_on = '0; note_off = '0; note_on0 = '0; note_off0 = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "timeout");
  end

  initial begin
    for (int v = 0; v < V; v++) exp_end[v] = -1;
    repeat (3) @(negedge clock_50_000_000);
    chk("rst_env", 32'(|envelope), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_end", 32'(envelope_end), 32'd0);
    reset_l = 1'b1;

    // Attack, decay to sustain, then release on voice 0.
    attack_rate = 24'h100000; decay_rate = 24'h010000;
    sustain_level = 16'h8000; release_rate = 24'h400000;
    wait_cyc(2);
    for (int k = 1; k <= 16; k++) q[0].push_back(16'(k * 32'h1000 - ((k == 16) ? 1 : 0)));
    for (int j = 1; j <= 127; j++) q[0].push_back(16'(32'hFFFF - j * 32'h100));
    q[0].push_back(16'h8000);
    q[0].push_back(16'h8000);
    q[0].push_back(16'h8000);
    pulse(4'b0001, '0, '0, '0);
    wait_cyc(1170);
    chk("active0_sustain", 32'(active[0]), 32'd1);
    chk("env0_sustain", 32'(envelope[0 +: OW]), 32'h8000);
    q[0].push_back(16'h4000);
    q[0].push_back(16'h0000);
    q[0].push_back(16'h0000);
    exp_end[0] = 1185;
    pulse('0, 4'b0001, '0, '0);
    wait_cyc(1186);
    chk("active0_after_release", 32'(active[0]), 32'd0);

    // Legato retrigger on voice 1 versus a non-legato copy.
    wait_cyc(1202);
    q[1].push_back(16'h1000); q[1].push_back(16'h2000); q[1].push_back(16'h3000);
    q0.push_back(16'h1000);   q0.push_back(16'h2000);   q0.push_back(16'h3000);
    pulse(4'b0010, '0, 4'b0010, '0);
    wait_cyc(1227);
    pulse('0, 4'b0010, '0, 4'b0010);
    q[1].push_back(16'h4000); q[1].push_back(16'h5000);
    q0.push_back(16'h1000);   q0.push_back(16'h2000);
    pulse(4'b0010, '0, 4'b0010, '0);
    wait_cyc(1244);
    release_rate = '0;
    q[1].push_back(16'h0000);
    q0.push_back(16'h0000);
    exp_end[1] = 1250;
    pulse('0, 4'b0010, '0, 4'b0010);
    wait_cyc(1251);
    chk("active1_zero_release", 32'(active[1]), 32'd0);

    // Simultaneous on/off on voice 2, note_off into idle voice 3.
    wait_cyc(1252);
    release_rate = 24'h400000;
    q[2].push_back(16'h1000); q[2].push_back(16'h2000);
    q[3].push_back(16'h0000); q[3].push_back(16'h0000);
    pulse(4'b0100, 4'b1100, '0, '0);
    chk("active2_on_wins", 32'(active[2]), 32'd1);
    chk("active3_off_idle", 32'(active[3]), 32'd0);
    wait_cyc(1268);
    release_rate = '0;
    q[2].push_back(16'h0000);
    exp_end[2] = 1275;
    pulse('0, 4'b0100, '0, '0);
    wait_cyc(1276);
    chk("active2_done", 32'(active[2]), 32'd0);

    // Zero attack and decay rates on all voices, then sustain tracking.
    attack_rate = '0; decay_rate = '0; sustain_level = 16'h6000;
    for (int v = 0; v < V; v++) begin
      q[v].push_back(16'hFFFF); q[v].push_back(16'h6000); q[v].push_back(16'h7000);
    end
    pulse(4'b1111, '0, '0, '0);
    wait_cyc(1281);
    chk("zr_v0_first", 32'(envelope[0*OW +: OW]), 32'hFFFF);
    chk("zr_v1_not_yet", 32'(envelope[1*OW +: OW]), 32'h0000);
    wait_cyc(1282);
    chk("zr_v1_second", 32'(envelope[1*OW +: OW]), 32'hFFFF);
    chk("zr_v2_not_yet", 32'(envelope[2*OW +: OW]), 32'h0000);
    wait_cyc(1283);
    chk("zr_v3_not_yet", 32'(envelope[3*OW +: OW]), 32'h0000);
    wait_cyc(1293);
    sustain_level = 16'h7000;

    // Mid-attack asynchronous reset with all voices active.
    wait_cyc(1301);
    attack_rate = 24'h100000;
    for (int v = 0; v < V; v++) q[v].push_back(16'h8000);
    pulse(4'b1111, '0, '0, '0);
    wait_cyc(1310);
    chk("pre_rst_active", 32'(active), 32'hF);
    for (int v = 0; v < V; v++) exp_end[v] = -1;
    #2 reset_l = 1'b0;
    #1;
    chk("async_rst_env", 32'(|envelope), 32'd0);
    chk("async_rst_active", 32'(active), 32'd0);
    chk("async_rst_end", 32'(envelope_end), 32'd0);
    repeat (2) @(negedge clock_50_000_000);
    reset_l = 1'b1;
    wait_cyc(2);
    q[0].push_back(16'h1000);
    pulse(4'b0001, '0, '0, '0);
    wait_cyc(8);
    chk("post_rst_no_service", 32'(envelope[0 +: OW]), 32'h0000);
    chk("post_rst_active0", 32'(active[0]), 32'd1);
    wait_cyc(9);
    chk("post_rst_first_service", 32'(envelope[0 +: OW]), 32'h1000);

    wait_cyc(20);
    for (int v = 0; v < V; v++) chk($sformatf("q_drained_v%0d", v), 32'(q[v].size()), 32'd0);
    chk("q_drained_nolegato", 32'(q0.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/envelope_bank.md
ENVELOPE_BANK -- requirements
Module: envelope_bank

Interface
REQ-001 SHALL have parameter VOICES, default 8: number of independent ADSR voices; must be at least 1.
REQ-002 SHALL have parameter OUT_WIDTH, default 16: envelope output width per voice.
REQ-003 SHALL have parameter FRAC_WIDTH, default 8: fractional accumulator bits; ACC_WIDTH = OUT_WIDTH+FRAC_WIDTH.
REQ-004 SHALL have parameter TICK_DIV, default 1042: clocks per generation tick; must be at least VOICES+1.
REQ-005 SHALL have parameter LEGATO, default 1: 1 = retrigger attacks from the current level; 0 = retrigger from zero.
REQ-006 SHALL have port clock_50_000_000, input, 1 bit: the single clock; all logic is rising-edge.
REQ-007 SHALL have port reset_l, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port note_on, input, VOICES bits: one-cycle note-on pulse per voice.
REQ-009 SHALL have port note_off, input, VOICES bits: one-cycle note-off pulse per voice.
REQ-010 SHALL have port attack_rate, input, ACC_WIDTH bits: accumulator increment per tick; 0 = instant.
REQ-011 SHALL have port decay_rate, input, ACC_WIDTH bits: decrement per tick; 0 = instant.
REQ-012 SHALL have port release_rate, input, ACC_WIDTH bits: decrement per tick; 0 = instant.
REQ-013 SHALL have port sustain_level, input, OUT_WIDTH bits: sustain target.
REQ-014 SHALL have port envelope, output, VOICES*OUT_WIDTH bits: voice v occupies bits [v*OUT_WIDTH +: OUT_WIDTH]; registered.
REQ-015 SHALL have port envelope_end, output, VOICES bits: one-cycle pulse when a voice's release reaches zero.
REQ-016 SHALL have port active, output, VOICES bits: high while the voice state is not IDLE.

Function
REQ-017 SHALL hold, per voice, a state in {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} and an ACC_WIDTH accumulator.
REQ-018 SHALL generate an internal tick every TICK_DIV clocks; on tick-cycle+1+v it services voice v, one voice per clock.
REQ-019 SHALL, for a serviced voice, write envelope slice v = accumulator[ACC_WIDTH-1:FRAC_WIDTH] on the same edge that updates the accumulator.
REQ-020 SHALL apply note_on to any state immediately: state becomes ATTACK; the accumulator is cleared if LEGATO=0 and kept if LEGATO=1.
REQ-021 SHALL apply note_off to ATTACK, DECAY or SUSTAIN immediately: state becomes RELEASE with the accumulator kept; note_off is ignored in IDLE and RELEASE.
REQ-022 SHALL give note_on priority over note_off when both are asserted for a voice in the same cycle.
REQ-023 SHALL, when an event and a service hit the same voice in the same cycle, take the event and skip that service.
REQ-024 SHALL service ATTACK as: acc + attack_rate, saturating at all-ones; on reaching all-ones, or if the rate is 0, set acc to all-ones and move to DECAY.
REQ-025 SHALL service DECAY as: acc - decay_rate, clamped at {sustain_level, FRAC zeros}; on reaching the clamp, or if the rate is 0, move to SUSTAIN.
REQ-026 SHALL service SUSTAIN as: acc = {sustain_level, FRAC zeros}, so that sustain_level changes are tracked.
REQ-027 SHALL service RELEASE as: acc - release_rate, clamped at 0; on reaching 0, or if the rate is 0, move to IDLE and pulse envelope_end[v] for one cycle.
REQ-028 SHALL leave IDLE voices with acc 0 and envelope 0.
REQ-029 SHALL perform all arithmetic at ACC_WIDTH+1 bits to detect overflow and underflow, with no wrap-around.
REQ-030 SHALL sample rates and sustain_level at service time without internal latching.

Reset
REQ-031 SHALL, on reset_l low, asynchronously set every voice to IDLE, accumulators to 0, envelope to 0, envelope_end to 0, active to 0, and the tick counter and service index to 0.
REQ-032 SHALL, on release of reset, emit the first tick TICK_DIV clocks later; a reset asserted mid-sweep aborts the sweep.

Verification (VOICES=4, OUT_WIDTH=16, FRAC_WIDTH=8, TICK_DIV=8)
REQ-033 SHALL cover attack: note_on[0], attack_rate=24'h100000, decay_rate=24'h010000, sustain_level=16'h8000 -> envelope[0] steps by 0x1000 per tick, reaches 0xFFFF after 16 ticks, then falls by 0x0100 per tick and holds at 0x8000 in SUSTAIN.
REQ-034 SHALL cover release: in SUSTAIN at 0x8000 with release_rate=24'h400000, note_off[0] -> 0x4000, then 0x0000 with envelope_end[0] high for exactly one cycle and active[0] low.
REQ-035 SHALL cover legato: LEGATO=1, note_on[1] during RELEASE at 0x3000 -> attack resumes from 0x3000; with LEGATO=0 the same stimulus restarts from 0x0000.
REQ-036 SHALL cover simultaneous events: note_on[2] and note_off[2] in the same cycle -> ATTACK; note_off in IDLE -> no change and no envelope_end pulse.
REQ-037 SHALL cover zero rates: attack_rate=0, decay_rate=0 -> envelope jumps to 0xFFFF on the first tick, to sustain_level on the second, and active voices 0-3 update on the consecutive clocks 1-4 after the tick.
REQ-038 SHALL cover reset: reset_l pulsed low mid-attack with voices 0-3 active -> all outputs 0 asynchronously, and no service occurs until 8 clocks after release.
